// File: rtl/floor_ctrl.sv
// Elevator car controller for floors 1..10.
// Latches floor buttons into a pending mask and moves the car with a SCAN policy.
// The car keeps its direction while requests lie ahead, opens the door at served floors,
// and drives an active-low 7-segment pattern of the current floor.
module floor_ctrl #(
  parameter int TRAVEL_TICKS = 100_000_000,
  parameter int DOOR_TICKS   = 200_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] req,
  output logic [7:0] display,
  output logic [3:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  floor_r, floor_s;
  logic [9:0]  pend_r, pend_s;
  logic [31:0] timer_r, timer_s;
  logic        last_up_r, last_up_s;

  logic        above_s, below_s, here_s;
  logic        travel_done_s, door_done_s;
  logic [3:0]  floor_up_s, floor_dn_s;

  // Bit i set when floor i+1 lies strictly above floor fl.
  function automatic logic [9:0] mask_above(input logic [3:0] fl);
    logic [9:0] m;
    for (int i = 0; i < 10; i++) begin
      m[i] = ((i + 1) > int'(fl));
    end
    return m;
  endfunction

  // Bit i set when floor i+1 lies strictly below floor fl.
  function automatic logic [9:0] mask_below(input logic [3:0] fl);
    logic [9:0] m;
    for (int i = 0; i < 10; i++) begin
      m[i] = ((i + 1) < int'(fl));
    end
    return m;
  endfunction

  // Bit i set only when floor i+1 equals floor fl.
  function automatic logic [9:0] mask_here(input logic [3:0] fl);
    logic [9:0] m;
    for (int i = 0; i < 10; i++) begin
      m[i] = ((i + 1) == int'(fl));
    end
    return m;
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; floor 10 shows '0', the display stage adds the leading '1'.
  function automatic logic [7:0] seg_encode(input logic [3:0] fl);
    logic [7:0] s;
    case (fl)
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      4'd10:   s = 8'hC0;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign floor = floor_r;

  // Request position relative to the car, timer terminal counts and clamped neighbour floors.
  always_comb begin
    above_s       = |(pend_r & mask_above(floor_r));
    below_s       = |(pend_r & mask_below(floor_r));
    here_s        = |(pend_r & mask_here(floor_r));
    travel_done_s = (timer_r == 32'(TRAVEL_TICKS - 1));
    door_done_s   = (timer_r == 32'(DOOR_TICKS - 1));
    floor_up_s    = (floor_r < 4'd10) ? (floor_r + 4'd1) : 4'd10;
    floor_dn_s    = (floor_r > 4'd1)  ? (floor_r - 4'd1) : 4'd1;
  end

  // Next-state decision: SCAN policy, travel/door timing, pending-request bookkeeping.
  always_comb begin
    state_s   = state_r;
    floor_s   = floor_r;
    timer_s   = timer_r;
    last_up_s = last_up_r;
    pend_s    = pend_r | req;
    case (state_r)
      ST_IDLE: begin
        timer_s = 32'd0;
        if (here_s) begin
          state_s = ST_DOOR;
        end else if (above_s && (last_up_r || !below_s)) begin
          state_s = ST_UP;
        end else if (below_s) begin
          state_s = ST_DOWN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UP: begin
        if (travel_done_s) begin
          floor_s   = floor_up_s;
          timer_s   = 32'd0;
          last_up_s = 1'b1;
          if (|(pend_r & mask_here(floor_up_s))) begin
            state_s = ST_DOOR;
          end else if (|(pend_r & mask_above(floor_up_s))) begin
            state_s = ST_UP;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r + 32'd1;
        end
      end
      ST_DOWN: begin
        if (travel_done_s) begin
          floor_s   = floor_dn_s;
          timer_s   = 32'd0;
          last_up_s = 1'b0;
          if (|(pend_r & mask_here(floor_dn_s))) begin
            state_s = ST_DOOR;
          end else if (|(pend_r & mask_below(floor_dn_s))) begin
            state_s = ST_DOWN;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          timer_s = timer_r + 32'd1;
        end
      end
      ST_DOOR: begin
        // A press at the current floor while the door is open is absorbed: clear wins over set.
        pend_s = (pend_r | req) & ~mask_here(floor_r);
        if (door_done_s) begin
          state_s = ST_IDLE;
          timer_s = 32'd0;
        end else begin
          timer_s = timer_r + 32'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = 32'd0;
      end
    endcase
  end

  // State, car position, request mask and registered status/display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      floor_r     <= 4'd1;
      pend_r      <= 10'd0;
      timer_r     <= 32'd0;
      last_up_r   <= 1'b1;
      display     <= 8'hF9;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      state_r     <= state_s;
      floor_r     <= floor_s;
      pend_r      <= pend_s;
      timer_r     <= timer_s;
      last_up_r   <= last_up_s;
      display     <= seg_encode(floor_r);
      moving_up   <= (state_s == ST_UP);
      moving_down <= (state_s == ST_DOWN);
      door_open   <= (state_s == ST_DOOR);
    end
  end

endmodule

// File: tb/tb_floor_ctrl.sv
// Self-checking bench for floor_ctrl with short travel/door periods.
// A behavioural car model (integer floor, pending array, mode and countdown) predicts every output each cycle.
module tb_floor_ctrl;
  localparam int TT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] req = 10'd0;
  logic [7:0] display;
  logic [3:0] floor;
  logic       moving_up, moving_down, door_open;

  floor_ctrl #(.TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .req(req), .display(display), .floor(floor),
    .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [1:10];

  // Model: mode 0 idle, 1 going up, 2 going down, 3 door open.
  int m_floor = 1;
  int m_disp_floor = 1;
  int m_mode = 0;
  int m_cnt = 0;
  bit m_last_up = 1'b1;
  bit m_pend [1:10];

  int door_log[$];
  logic prev_door = 1'b0;

  function automatic bit any_above(int f);
    for (int k = f + 1; k <= 10; k++) if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(int f);
    for (int k = 1; k < f; k++) if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_quiet();
    if (m_mode != 0) return 1'b0;
    for (int k = 1; k <= 10; k++) if (m_pend[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic [9:0] r, input logic rst);
    bit np [1:10];
    if (rst) begin
      m_floor = 1; m_disp_floor = 1; m_mode = 0; m_cnt = 0; m_last_up = 1'b1;
      for (int k = 1; k <= 10; k++) m_pend[k] = 1'b0;
      return;
    end
    m_disp_floor = m_floor;
    for (int k = 1; k <= 10; k++) np[k] = m_pend[k] | r[k-1];
    if (m_mode == 0) begin
      if (m_pend[m_floor]) m_mode = 3;
      else if (any_above(m_floor) && (m_last_up || !any_below(m_floor))) m_mode = 1;
      else if (any_below(m_floor)) m_mode = 2;
      m_cnt = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_cnt == TT - 1) begin
        m_floor = (m_mode == 1) ? m_floor + 1 : m_floor - 1;
        m_last_up = (m_mode == 1);
        m_cnt = 0;
        if (m_pend[m_floor]) m_mode = 3;
        else if (m_mode == 1 && any_above(m_floor)) m_mode = 1;
        else if (m_mode == 2 && any_below(m_floor)) m_mode = 2;
        else m_mode = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      np[m_floor] = 1'b0;
      if (m_cnt == DT - 1) begin m_mode = 0; m_cnt = 0; end
      else m_cnt++;
    end
    for (int k = 1; k <= 10; k++) m_pend[k] = np[k];
  endtask

  // Drives one clock of stimulus, advances the model and compares every output.
  task automatic step(input logic [9:0] r, input logic rst);
    req = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    #1;
    checks++;
    if (floor !== 4'(m_floor)) begin
      errors++; $display("FAIL floor: got %0d expected %0d at %0t", floor, m_floor, $time);
    end
    checks++;
    if (display !== seg_tab[m_disp_floor]) begin
      errors++; $display("FAIL display: got %h expected %h at %0t", display, seg_tab[m_disp_floor], $time);
    end
    checks++;
    if ({moving_up, moving_down, door_open} !== {m_mode == 1, m_mode == 2, m_mode == 3}) begin
      errors++;
      $display("FAIL status: got up/dn/door=%b%b%b expected mode %0d at %0t",
               moving_up, moving_down, door_open, m_mode, $time);
    end
    checks++;
    if (floor == 4'd10 && moving_up) begin
      errors++; $display("FAIL up_at_top: got moving_up=1 at floor 10 expected 0 at %0t", $time);
    end
    if (door_open === 1'b1 && prev_door !== 1'b1) door_log.push_back(int'(floor));
    prev_door = door_open;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (!model_quiet() && n < max) begin
      step(10'd0, 1'b0);
      n++;
    end
    checks++;
    if (!model_quiet()) begin
      errors++; $display("FAIL drain_timeout: got still busy after %0d cycles expected idle", max);
    end
    step(10'd0, 1'b0);
  endtask

  task automatic test_reset();
    step(10'd0, 1'b1);
    step(10'd0, 1'b1);
    checks++;
    if ({floor, display, moving_up, moving_down, door_open} !== {4'd1, 8'hF9, 3'b000}) begin
      errors++; $display("FAIL reset_state: got floor=%0d disp=%h st=%b%b%b expected 1 F9 000",
                         floor, display, moving_up, moving_down, door_open);
    end
    for (int i = 0; i < 5; i++) step(10'd0, 1'b0);
    checks++;
    if (floor !== 4'd1 || moving_up !== 1'b0 || door_open !== 1'b0) begin
      errors++; $display("FAIL reset_pend_empty: got floor=%0d up=%b door=%b expected 1 0 0", floor, moving_up, door_open);
    end
  endtask

  task automatic test_door_here();
    door_log.delete();
    step(10'b00_0000_0001, 1'b0);
    checks++;
    if (door_open !== 1'b0) begin
      errors++; $display("FAIL door_here_early: got %b expected 0", door_open);
    end
    step(10'd0, 1'b0);
    checks++;
    if (door_open !== 1'b1) begin
      errors++; $display("FAIL door_here_latency: got %b expected 1", door_open);
    end
    drain(50);
    checks++;
    if (door_log.size() != 1 || floor !== 4'd1) begin
      errors++; $display("FAIL door_here_nomove: got doors=%0d floor=%0d expected 1 1", door_log.size(), floor);
    end
  endtask

  task automatic test_up_trip();
    int door_cycles = 0;
    bit saw_up = 1'b0;
    logic [7:0] disp_seen [$];
    step(10'b00_0001_0000, 1'b0);
    for (int i = 0; i < 60 && !(model_quiet() && door_cycles > 0); i++) begin
      step(10'd0, 1'b0);
      if (moving_up) saw_up = 1'b1;
      if (door_open && floor == 4'd5) door_cycles++;
      if (disp_seen.size() == 0 || disp_seen[$] != display) disp_seen.push_back(display);
    end
    checks++;
    if (door_cycles != 3 || !saw_up || floor !== 4'd5) begin
      errors++; $display("FAIL up_trip: got door_cycles=%0d saw_up=%b floor=%0d expected 3 1 5", door_cycles, saw_up, floor);
    end
    checks++;
    if (disp_seen.size() != 5 || disp_seen[1] != 8'hA4 || disp_seen[2] != 8'hB0 ||
        disp_seen[3] != 8'h99 || disp_seen[4] != 8'h92) begin
      errors++; $display("FAIL up_trip_display: got %0d distinct values expected F9 A4 B0 99 92", disp_seen.size());
    end
  endtask

  task automatic test_mid_travel();
    door_log.delete();
    step(10'b00_1000_0000, 1'b0);
    for (int i = 0; i < 6; i++) step(10'd0, 1'b0);
    step(10'b00_0000_0100, 1'b0);
    drain(200);
    checks++;
    if (door_log.size() != 2 || door_log[0] != 8 || door_log[1] != 3) begin
      errors++; $display("FAIL mid_travel_order: got %0d doors first=%0d expected 8 then 3",
                         door_log.size(), (door_log.size() > 0) ? door_log[0] : 0);
    end
  endtask

  task automatic test_top();
    step(10'b10_0000_0000, 1'b0);
    drain(200);
    checks++;
    if (floor !== 4'd10 || display !== 8'hC0) begin
      errors++; $display("FAIL top_floor: got floor=%0d disp=%h expected 10 C0", floor, display);
    end
  endtask

  task automatic test_reset_mid_move();
    int n = 0;
    step(10'b00_0000_0001, 1'b0);
    while (!(moving_down && m_floor <= 8) && n < 100) begin
      step(10'd0, 1'b0);
      n++;
    end
    step(10'd0, 1'b1);
    checks++;
    if ({floor, display, moving_up, moving_down, door_open} !== {4'd1, 8'hF9, 3'b000}) begin
      errors++; $display("FAIL reset_mid_move: got floor=%0d disp=%h st=%b%b%b expected 1 F9 000",
                         floor, display, moving_up, moving_down, door_open);
    end
    for (int i = 0; i < 8; i++) step(10'd0, 1'b0);
    checks++;
    if (door_open !== 1'b0 || moving_up !== 1'b0 || floor !== 4'd1) begin
      errors++; $display("FAIL reset_pend_clear: got up=%b door=%b floor=%0d expected 0 0 1", moving_up, door_open, floor);
    end
    door_log.delete();
    step(10'b00_0000_1000, 1'b0);
    drain(200);
    checks++;
    if (door_log.size() != 1 || door_log[0] != 4) begin
      errors++; $display("FAIL after_reset_serve: got doors=%0d expected one at floor 4", door_log.size());
    end
  endtask

  task automatic test_random();
    logic [9:0] r;
    for (int i = 0; i < 400; i++) begin
      r = 10'd0;
      if ($urandom_range(0, 9) == 0) r[$urandom_range(0, 9)] = 1'b1;
      if ($urandom_range(0, 29) == 0) r = 10'($urandom);
      step(r, 1'b0);
    end
    drain(600);
  endtask

  initial begin
    seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0; seg_tab[4] = 8'h99; seg_tab[5] = 8'h92;
    seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8; seg_tab[8] = 8'h80; seg_tab[9] = 8'h90; seg_tab[10] = 8'hC0;
    for (int k = 1; k <= 10; k++) m_pend[k] = 1'b0;
    test_reset();
    test_door_here();
    test_up_trip();
    test_mid_travel();
    test_top();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
